// File: rtl/sram_req_arbiter.sv
// Arbiter between instruction and data masters onto one single-port SRAM.
// One transaction in flight; a starvation guard bounds inst lockout by data traffic.
module sram_req_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        owner_data;
  logic        is_read;
  logic        inst_ok_q;
  logic        data_ok_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

  logic can_arb;
  logic inst_wins;
  logic grant_inst;
  logic grant_data;

  // Data has priority unless the inst port has been passed over STARVE_MAX times.
  assign can_arb    = !reset && (state == IDLE || state == RESP);
  assign inst_wins  = inst_req && (!data_req || starve_cnt == 4'(STARVE_MAX));
  assign grant_inst = can_arb && inst_wins;
  assign grant_data = can_arb && data_req && !inst_wins;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign ram_en       = grant_inst || grant_data;
  assign ram_wen      = (grant_data && data_wr) ? data_wstrb : 4'b0;
  assign ram_wdata    = grant_data ? data_wdata : 32'b0;
  assign ram_addr     = grant_data ? data_addr : (grant_inst ? inst_addr : 32'b0);

  // Registered responses are forced low during the reset cycle itself.
  assign inst_data_ok = inst_ok_q && !reset;
  assign data_data_ok = data_ok_q && !reset;
  assign inst_rdata   = reset ? 32'b0 : inst_rdata_q;
  assign data_rdata   = reset ? 32'b0 : data_rdata_q;
  assign busy         = (state == WAIT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= 2'd0;
      starve_cnt   <= 4'd0;
      owner_data   <= 1'b1;
      is_read      <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'b0;
      data_rdata_q <= 32'b0;
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_inst || grant_data) begin
            state      <= WAIT;
            owner_data <= grant_data;
            is_read    <= grant_inst || !data_wr;
            lat_cnt    <= 2'(LAT - 1);
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else begin
            state <= RESP;
            if (owner_data) begin
              data_ok_q <= 1'b1;
              if (is_read) data_rdata_q <= ram_rdata;
            end else begin
              inst_ok_q <= 1'b1;
              if (is_read) inst_rdata_q <= ram_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Count data grants that bypass a waiting inst request; saturate at STARVE_MAX.
      if (grant_inst) begin
        starve_cnt <= 4'd0;
      end else if (grant_data) begin
        if (!inst_req)
          starve_cnt <= 4'd0;
        else if (starve_cnt != 4'(STARVE_MAX))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: three instances (LAT 1/2/3) share inputs,
// each scenario checks one instance against hand-computed cycle-by-cycle values.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, ram_rdata;
  logic [3:0]  data_wstrb;

  logic        u1_inst_addr_ok, u1_inst_data_ok, u1_data_addr_ok, u1_data_data_ok, u1_ram_en, u1_busy;
  logic [31:0] u1_inst_rdata, u1_data_rdata, u1_ram_addr, u1_ram_wdata;
  logic [3:0]  u1_ram_wen;
  logic        u2_inst_addr_ok, u2_inst_data_ok, u2_data_addr_ok, u2_data_data_ok, u2_ram_en, u2_busy;
  logic [31:0] u2_inst_rdata, u2_data_rdata, u2_ram_addr, u2_ram_wdata;
  logic [3:0]  u2_ram_wen;
  logic        u3_inst_addr_ok, u3_inst_data_ok, u3_data_addr_ok, u3_data_data_ok, u3_ram_en, u3_busy;
  logic [31:0] u3_inst_rdata, u3_data_rdata, u3_ram_addr, u3_ram_wdata;
  logic [3:0]  u3_ram_wen;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(u1_inst_addr_ok),
    .inst_data_ok(u1_inst_data_ok), .inst_rdata(u1_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(u1_data_addr_ok), .data_data_ok(u1_data_data_ok),
    .data_rdata(u1_data_rdata), .ram_en(u1_ram_en), .ram_wen(u1_ram_wen), .ram_addr(u1_ram_addr),
    .ram_wdata(u1_ram_wdata), .ram_rdata(ram_rdata), .busy(u1_busy)
  );

  sram_req_arbiter #(.LAT(2), .STARVE_MAX(4)) u2 (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(u2_inst_addr_ok),
    .inst_data_ok(u2_inst_data_ok), .inst_rdata(u2_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(u2_data_addr_ok), .data_data_ok(u2_data_data_ok),
    .data_rdata(u2_data_rdata), .ram_en(u2_ram_en), .ram_wen(u2_ram_wen), .ram_addr(u2_ram_addr),
    .ram_wdata(u2_ram_wdata), .ram_rdata(ram_rdata), .busy(u2_busy)
  );

  sram_req_arbiter #(.LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(u3_inst_addr_ok),
    .inst_data_ok(u3_inst_data_ok), .inst_rdata(u3_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(u3_data_addr_ok), .data_data_ok(u3_data_data_ok),
    .data_rdata(u3_data_rdata), .ram_en(u3_ram_en), .ram_wen(u3_ram_wen), .ram_addr(u3_ram_addr),
    .ram_wdata(u3_ram_wdata), .ram_rdata(ram_rdata), .busy(u3_busy)
  );

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'b0;
    inst_addr = 32'b0; data_addr = 32'b0; data_wdata = 32'b0; ram_rdata = 32'b0;
  endtask

  // Leaves the bench in the first cycle with reset low, all instances idle.
  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h10; inst_addr = 32'h20;
    @(negedge clk);
    if (u1_inst_addr_ok !== 1'b0) $display("[TB] FAIL rst_inst_addr_ok: got %b want 0", u1_inst_addr_ok); else pass_cnt++; total_cnt++;
    if (u1_data_addr_ok !== 1'b0) $display("[TB] FAIL rst_data_addr_ok: got %b want 0", u1_data_addr_ok); else pass_cnt++; total_cnt++;
    if (u1_ram_en !== 1'b0 || u1_ram_addr !== 32'b0) $display("[TB] FAIL rst_ram: got en=%b addr=%h want 0/0", u1_ram_en, u1_ram_addr); else pass_cnt++; total_cnt++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    if (u1_busy !== 1'b0 || u1_inst_data_ok !== 1'b0 || u1_data_data_ok !== 1'b0) $display("[TB] FAIL rst_state: got busy=%b iok=%b dok=%b want 0/0/0", u1_busy, u1_inst_data_ok, u1_data_data_ok); else pass_cnt++; total_cnt++;
    if (u1_inst_rdata !== 32'b0 || u1_data_rdata !== 32'b0) $display("[TB] FAIL rst_rdata: got %h/%h want 0/0", u1_inst_rdata, u1_data_rdata); else pass_cnt++; total_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_inst_read();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'hbfc00000;
    @(negedge clk);
    if (u1_inst_addr_ok !== 1'b1 || u1_ram_en !== 1'b1) $display("[TB] FAIL iread_grant: got aok=%b en=%b want 1/1", u1_inst_addr_ok, u1_ram_en); else pass_cnt++; total_cnt++;
    if (u1_ram_wen !== 4'b0 || u1_ram_addr !== 32'hbfc00000) $display("[TB] FAIL iread_ram: got wen=%b addr=%h want 0000/bfc00000", u1_ram_wen, u1_ram_addr); else pass_cnt++; total_cnt++;
    next_cycle();
    inst_req = 1'b0; ram_rdata = 32'h3c1d0001;
    @(negedge clk);
    if (u1_busy !== 1'b1 || u1_inst_data_ok !== 1'b0) $display("[TB] FAIL iread_wait: got busy=%b iok=%b want 1/0", u1_busy, u1_inst_data_ok); else pass_cnt++; total_cnt++;
    next_cycle();
    ram_rdata = 32'h0;
    @(negedge clk);
    if (u1_inst_data_ok !== 1'b1 || u1_inst_rdata !== 32'h3c1d0001) $display("[TB] FAIL iread_resp: got iok=%b rdata=%h want 1/3c1d0001", u1_inst_data_ok, u1_inst_rdata); else pass_cnt++; total_cnt++;
    if (u1_data_data_ok !== 1'b0 || u1_busy !== 1'b0) $display("[TB] FAIL iread_other: got dok=%b busy=%b want 0/0", u1_data_data_ok, u1_busy); else pass_cnt++; total_cnt++;
    next_cycle();
    @(negedge clk);
    if (u1_inst_data_ok !== 1'b0 || u1_inst_rdata !== 32'h3c1d0001) $display("[TB] FAIL iread_after: got iok=%b rdata=%h want 0/3c1d0001", u1_inst_data_ok, u1_inst_rdata); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_data_write();
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h100; data_wdata = 32'h12345678;
    @(negedge clk);
    if (u1_data_addr_ok !== 1'b1 || u1_ram_wen !== 4'b0011) $display("[TB] FAIL dwr_grant: got aok=%b wen=%b want 1/0011", u1_data_addr_ok, u1_ram_wen); else pass_cnt++; total_cnt++;
    if (u1_ram_wdata !== 32'h12345678 || u1_ram_addr !== 32'h100) $display("[TB] FAIL dwr_ram: got wdata=%h addr=%h want 12345678/00000100", u1_ram_wdata, u1_ram_addr); else pass_cnt++; total_cnt++;
    next_cycle();
    clear_inputs(); ram_rdata = 32'hdeadbeef;
    @(negedge clk);
    if (u1_data_data_ok !== 1'b0 || u1_ram_wen !== 4'b0) $display("[TB] FAIL dwr_wait: got dok=%b wen=%b want 0/0000", u1_data_data_ok, u1_ram_wen); else pass_cnt++; total_cnt++;
    next_cycle();
    ram_rdata = 32'h0;
    @(negedge clk);
    if (u1_data_data_ok !== 1'b1 || u1_data_rdata !== 32'h0) $display("[TB] FAIL dwr_resp: got dok=%b rdata=%h want 1/00000000", u1_data_data_ok, u1_data_rdata); else pass_cnt++; total_cnt++;
    next_cycle();
    @(negedge clk);
    if (u1_data_data_ok !== 1'b0) $display("[TB] FAIL dwr_pulse: got dok=%b want 0", u1_data_data_ok); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1000; data_req = 1'b1; data_addr = 32'h2000;
    @(negedge clk);
    if (u1_data_addr_ok !== 1'b1 || u1_inst_addr_ok !== 1'b0) $display("[TB] FAIL sim_T: got daok=%b iaok=%b want 1/0", u1_data_addr_ok, u1_inst_addr_ok); else pass_cnt++; total_cnt++;
    if (u1_ram_addr !== 32'h2000) $display("[TB] FAIL sim_T_addr: got %h want 00002000", u1_ram_addr); else pass_cnt++; total_cnt++;
    next_cycle();
    data_req = 1'b0; ram_rdata = 32'haaaa5555;
    @(negedge clk);
    if (u1_inst_addr_ok !== 1'b0) $display("[TB] FAIL sim_T1: got iaok=%b want 0", u1_inst_addr_ok); else pass_cnt++; total_cnt++;
    next_cycle();
    @(negedge clk);
    if (u1_data_data_ok !== 1'b1 || u1_data_rdata !== 32'haaaa5555) $display("[TB] FAIL sim_T2_resp: got dok=%b rdata=%h want 1/aaaa5555", u1_data_data_ok, u1_data_rdata); else pass_cnt++; total_cnt++;
    if (u1_inst_addr_ok !== 1'b1 || u1_ram_addr !== 32'h1000) $display("[TB] FAIL sim_T2_grant: got iaok=%b addr=%h want 1/00001000", u1_inst_addr_ok, u1_ram_addr); else pass_cnt++; total_cnt++;
    next_cycle();
    inst_req = 1'b0; ram_rdata = 32'h11112222;
    @(negedge clk);
    if (u1_inst_data_ok !== 1'b0 || u1_data_data_ok !== 1'b0) $display("[TB] FAIL sim_T3: got iok=%b dok=%b want 0/0", u1_inst_data_ok, u1_data_data_ok); else pass_cnt++; total_cnt++;
    next_cycle();
    @(negedge clk);
    if (u1_inst_data_ok !== 1'b1 || u1_inst_rdata !== 32'h11112222) $display("[TB] FAIL sim_T4: got iok=%b rdata=%h want 1/11112222", u1_inst_data_ok, u1_inst_rdata); else pass_cnt++; total_cnt++;
    if (u1_data_rdata !== 32'haaaa5555) $display("[TB] FAIL sim_T4_drdata: got %h want aaaa5555", u1_data_rdata); else pass_cnt++; total_cnt++;
  endtask

  // With both requests held, grants go D D D D I, then repeat.
  task automatic test_starvation();
    int grants = 0;
    logic exp_inst;
    do_reset();
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h400; data_addr = 32'h800;
    for (int cyc = 0; cyc < 40 && grants < 10; cyc++) begin
      @(negedge clk);
      if (u1_inst_addr_ok || u1_data_addr_ok) begin
        exp_inst = (grants == 4) || (grants == 9);
        if (u1_inst_addr_ok !== exp_inst || u1_data_addr_ok !== !exp_inst) $display("[TB] FAIL starve_grant%0d: got inst=%b data=%b want inst=%b", grants, u1_inst_addr_ok, u1_data_addr_ok, exp_inst); else pass_cnt++; total_cnt++;
        grants++;
      end
      next_cycle();
    end
    if (grants !== 10) $display("[TB] FAIL starve_count: got %0d grants want 10", grants); else pass_cnt++; total_cnt++;
    clear_inputs();
  endtask

  task automatic test_lat3();
    do_reset();
    data_req = 1'b1; data_addr = 32'h40;
    @(negedge clk);
    if (u3_data_addr_ok !== 1'b1) $display("[TB] FAIL lat3_grant: got %b want 1", u3_data_addr_ok); else pass_cnt++; total_cnt++;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      ram_rdata = (k == 3) ? 32'hcafef00d : 32'h11111111;
      @(negedge clk);
      if (u3_data_addr_ok !== 1'b0 || u3_busy !== 1'b1 || u3_data_data_ok !== 1'b0) $display("[TB] FAIL lat3_wait%0d: got aok=%b busy=%b dok=%b want 0/1/0", k, u3_data_addr_ok, u3_busy, u3_data_data_ok); else pass_cnt++; total_cnt++;
    end
    next_cycle();
    data_req = 1'b0; ram_rdata = 32'h0;
    @(negedge clk);
    if (u3_data_data_ok !== 1'b1 || u3_data_rdata !== 32'hcafef00d) $display("[TB] FAIL lat3_resp: got dok=%b rdata=%h want 1/cafef00d", u3_data_data_ok, u3_data_rdata); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    data_req = 1'b1; data_addr = 32'h80;
    @(negedge clk);
    if (u2_data_addr_ok !== 1'b1) $display("[TB] FAIL rmid_grant: got %b want 1", u2_data_addr_ok); else pass_cnt++; total_cnt++;
    next_cycle();
    data_req = 1'b0; reset = 1'b1; ram_rdata = 32'h5a5a5a5a;
    @(negedge clk);
    if (u2_busy !== 1'b0 || u2_ram_en !== 1'b0) $display("[TB] FAIL rmid_T1: got busy=%b en=%b want 0/0", u2_busy, u2_ram_en); else pass_cnt++; total_cnt++;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    if (u2_busy !== 1'b0 || u2_data_data_ok !== 1'b0 || u2_data_rdata !== 32'h0 || u2_ram_en !== 1'b0 || u2_ram_addr !== 32'h0) $display("[TB] FAIL rmid_T2: got busy=%b dok=%b rdata=%h en=%b addr=%h want all 0", u2_busy, u2_data_data_ok, u2_data_rdata, u2_ram_en, u2_ram_addr); else pass_cnt++; total_cnt++;
    for (int k = 3; k <= 6; k++) begin
      next_cycle();
      @(negedge clk);
      if (u2_data_data_ok !== 1'b0 || u2_data_rdata !== 32'h0) $display("[TB] FAIL rmid_T%0d: got dok=%b rdata=%h want 0/0", k, u2_data_data_ok, u2_data_rdata); else pass_cnt++; total_cnt++;
    end
    next_cycle();
    reset = 1'b1; data_req = 1'b1; data_addr = 32'h84;
    @(negedge clk);
    if (u2_data_addr_ok !== 1'b0) $display("[TB] FAIL rmid_in_reset: got aok=%b want 0", u2_data_addr_ok); else pass_cnt++; total_cnt++;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    if (u2_data_addr_ok !== 1'b1 || u2_ram_addr !== 32'h84) $display("[TB] FAIL rmid_first: got aok=%b addr=%h want 1/00000084", u2_data_addr_ok, u2_ram_addr); else pass_cnt++; total_cnt++;
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_inst_read();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_lat3();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
